// File: rtl/bbox_draw_if.sv
// Pixel-writer bus between a box-outline controller and a byte-addressed frame buffer.
// Carries the draw request/status handshake and the stallable byte-write port.
// The slave side is the drawing engine; the master side is the requester plus memory.
interface bbox_draw_if;
  // request / status
  logic        start;
  logic        done;
  logic        err;
  logic [10:0] xMin;
  logic [10:0] xMax;
  logic [10:0] yMin;
  logic [10:0] yMax;
  // byte write port toward the frame buffer
  logic [31:0] addr;
  logic [15:0] wrdata;
  logic        wren;
  logic        waitrequest;

  modport slave (
    input  start, xMin, xMax, yMin, yMax, waitrequest,
    output done, err, addr, wrdata, wren
  );

  modport master (
    output start, xMin, xMax, yMin, yMax, waitrequest,
    input  done, err, addr, wrdata, wren
  );
endinterface

// File: rtl/bbox_draw.sv
// Draws a one-pixel rectangle outline into a bottom-up 24-bit BGR frame buffer.
// Latency: first byte write is presented on the edge after start; one byte per cycle.
// Backpressure: waitrequest holds addr/wrdata/wren frozen until the write is accepted.
module bbox_draw #(
  parameter int          WIDTH  = 100,
  parameter int          HEIGHT = 100,
  parameter logic [23:0] COLOUR = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst,
  bbox_draw_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOP    = 3'd1,
    BOTTOM = 3'd2,
    LEFT   = 3'd3,
    RIGHT  = 3'd4,
    FIN    = 3'd5
  } state_t;

  // FSM state and latched box
  state_t      r_state;
  logic [10:0] r_xmin;
  logic [10:0] r_xmax;
  logic [10:0] r_ymin;
  logic [10:0] r_ymax;

  // current pixel and byte lane (0 = B, 1 = G, 2 = R)
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [1:0]  r_c;

  // registered outputs
  logic        r_done;
  logic        r_err;
  logic        r_wren;
  logic [31:0] r_addr;
  logic [15:0] r_wrdata;

  // next-pixel decision for the byte-2 acceptance edge
  state_t      w_nstate;
  logic [10:0] w_nx;
  logic [10:0] w_ny;
  logic        w_last;
  logic [10:0] w_span;
  logic        w_bad;
  logic        w_accept;

  // Frame buffer is stored bottom row first, three bytes per pixel.
  // All arithmetic is done at 32 bits so large frames do not wrap.
  function automatic logic [31:0] pix_addr(input logic [10:0] x,
                                           input logic [10:0] y,
                                           input logic [1:0]  c);
    logic [31:0] row;
    row = 32'(HEIGHT) - 32'd1 - {21'd0, y};
    return (row * 32'(WIDTH) * 32'd3) + ({21'd0, x} * 32'd3) + {30'd0, c};
  endfunction

  // Byte lane 0 carries blue (top byte of COLOUR), lane 2 carries red.
  function automatic logic [15:0] pix_byte(input logic [1:0] c);
    logic [15:0] b;
    case (c)
      2'd0:    b = {8'h00, COLOUR[23:16]};
      2'd1:    b = {8'h00, COLOUR[15:8]};
      default: b = {8'h00, COLOUR[7:0]};
    endcase
    return b;
  endfunction

  // Request is rejected when the box is inverted or runs off the frame.
  assign w_bad = (bus.xMin > bus.xMax) ||
                 (bus.yMin > bus.yMax) ||
                 ({21'd0, bus.xMax} >= 32'(WIDTH)) ||
                 ({21'd0, bus.yMax} >= 32'(HEIGHT));

  assign w_span   = r_ymax - r_ymin;
  assign w_accept = r_wren && !bus.waitrequest;

  // Pick the pixel after the current one, skipping degenerate edges so
  // corner pixels are written exactly once.
  always_comb begin
    w_nstate = r_state;
    w_nx     = r_x;
    w_ny     = r_y;
    w_last   = 1'b0;
    case (r_state)
      TOP: begin
        if (r_x != r_xmax) begin
          w_nx = r_x + 11'd1;
        end else if (r_ymax != r_ymin) begin
          w_nstate = BOTTOM;
          w_nx     = r_xmin;
          w_ny     = r_ymax;
        end else begin
          w_last = 1'b1;
        end
      end
      BOTTOM: begin
        if (r_x != r_xmax) begin
          w_nx = r_x + 11'd1;
        end else if (w_span >= 11'd2) begin
          w_nstate = LEFT;
          w_nx     = r_xmin;
          w_ny     = r_ymin + 11'd1;
        end else begin
          w_last = 1'b1;
        end
      end
      LEFT: begin
        if (r_y != (r_ymax - 11'd1)) begin
          w_ny = r_y + 11'd1;
        end else if (r_xmax != r_xmin) begin
          w_nstate = RIGHT;
          w_nx     = r_xmax;
          w_ny     = r_ymin + 11'd1;
        end else begin
          w_last = 1'b1;
        end
      end
      RIGHT: begin
        if (r_y != (r_ymax - 11'd1)) begin
          w_ny = r_y + 11'd1;
        end else begin
          w_last = 1'b1;
        end
      end
      default: begin
        w_last = 1'b0;
      end
    endcase
  end

  // Main FSM: request acceptance, byte stepping on accepted writes, completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_c      <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wren   <= 1'b0;
      r_addr   <= '0;
      r_wrdata <= '0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (bus.start) begin
            r_xmin <= bus.xMin;
            r_xmax <= bus.xMax;
            r_ymin <= bus.yMin;
            r_ymax <= bus.yMax;
            if (w_bad) begin
              // rejected: report immediately, bus stays quiet
              r_state <= FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              // first byte is presented straight from the request inputs
              r_state  <= TOP;
              r_done   <= 1'b0;
              r_err    <= 1'b0;
              r_x      <= bus.xMin;
              r_y      <= bus.yMin;
              r_c      <= 2'd0;
              r_wren   <= 1'b1;
              r_addr   <= pix_addr(bus.xMin, bus.yMin, 2'd0);
              r_wrdata <= pix_byte(2'd0);
            end
          end
        end
        default: begin
          // drawing states: start is ignored, advance only on acceptance
          if (w_accept) begin
            if (r_c != 2'd2) begin
              r_c      <= r_c + 2'd1;
              r_addr   <= pix_addr(r_x, r_y, r_c + 2'd1);
              r_wrdata <= pix_byte(r_c + 2'd1);
            end else if (w_last) begin
              r_state  <= FIN;
              r_done   <= 1'b1;
              r_wren   <= 1'b0;
              r_addr   <= '0;
              r_wrdata <= '0;
              r_c      <= 2'd0;
            end else begin
              r_state  <= w_nstate;
              r_x      <= w_nx;
              r_y      <= w_ny;
              r_c      <= 2'd0;
              r_addr   <= pix_addr(w_nx, w_ny, 2'd0);
              r_wrdata <= pix_byte(2'd0);
            end
          end
        end
      endcase
    end
  end

  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.wren   = r_wren;
  assign bus.addr   = r_addr;
  assign bus.wrdata = r_wrdata;

endmodule

// File: doc/bbox_draw.md
BBOX_DRAW -- requirements
Module: bbox_draw

Interface
REQ-001 SHALL have parameter WIDTH, default 100, image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 100, image height in pixels.
REQ-003 SHALL have parameter COLOUR, default 24'h0000FF, outline colour {B,G,R} with B in bits 23:16 and R in bits 7:0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request to draw one outline.
REQ-007 SHALL have port done, output, 1 bit: outline complete.
REQ-008 SHALL have port err, output, 1 bit: last request rejected.
REQ-009 SHALL have ports xMin, xMax, yMin, yMax, input, 11 bits each: box corners in pixel coordinates, y=0 at the top row.
REQ-010 SHALL have port addr, output, 32 bits: byte address of the current write.
REQ-011 SHALL have port wrdata, output, 16 bits: write byte in bits 7:0, with bits 15:8 = 0.
REQ-012 SHALL have port wren, output, 1 bit: write request.
REQ-013 SHALL have port waitrequest, input, 1 bit: memory stall.

Function
REQ-014 SHALL use states IDLE, TOP, BOTTOM, LEFT, RIGHT and FIN.
REQ-015 SHALL, in IDLE or FIN with start=1, latch all four coordinates and clear done and err on the same edge.
REQ-016 SHALL, on that edge, check the latched coordinates:
- If xMin>xMax, yMin>yMax, xMax>=WIDTH or yMax>=HEIGHT, go to FIN with err=1 and make no writes.
- Otherwise go to TOP.
REQ-017 SHALL ignore start in TOP, BOTTOM, LEFT and RIGHT.
REQ-018 SHALL write pixels in this order:
- TOP: y=yMin, x from xMin to xMax.
- BOTTOM: y=yMax, x from xMin to xMax.
- LEFT: x=xMin, y from yMin+1 to yMax-1.
- RIGHT: x=xMax, y from yMin+1 to yMax-1.
REQ-019 SHALL skip BOTTOM when yMax==yMin.
REQ-020 SHALL skip LEFT and RIGHT when yMax-yMin<2.
REQ-021 SHALL skip RIGHT when xMax==xMin.
REQ-022 SHALL write each pixel exactly once, so the number of writes is 3×(perimeter pixel count).
REQ-023 SHALL issue three byte writes per pixel, c=0,1,2, with addr = (HEIGHT-y-1)×WIDTH×3 + x×3 + c.
REQ-024 SHALL drive wrdata per byte: c=0 gives COLOUR[23:16], c=1 gives COLOUR[15:8], c=2 gives COLOUR[7:0].
REQ-025 SHALL compute addr with at least 32-bit intermediate width and no truncation.
REQ-026 SHALL assert wren continuously in the drawing states.
REQ-027 SHALL count a write as accepted only on an edge where wren=1 and waitrequest=0.
REQ-028 SHALL hold addr and wrdata stable while waitrequest=1.
REQ-029 SHALL present the next write on the cycle after acceptance, giving one byte per cycle when waitrequest=0.
REQ-030 SHALL deassert wren on the edge that accepts the final write, enter FIN there and raise done on that edge.
REQ-031 SHALL hold done=1 and err at their values in FIN until the next accepted start.
REQ-032 SHALL drive addr=0 and wrdata=0 whenever wren=0.

Reset
REQ-033 SHALL, while rst=1, immediately and asynchronously force state=IDLE, done=0, err=0, wren=0, addr=0 and wrdata=0, regardless of clk.
REQ-034 SHALL resume normally on the first edge after rst falls, accepting start from IDLE.
REQ-035 SHALL abandon a reset mid-draw with no further writes; the bench does not check memory contents already written.

Verification
REQ-036 SHALL pass this scenario: box (10,20)-(12,22) with waitrequest=0 -> exactly 24 writes, the first at addr 23730 with data 0x00, done=1 on the cycle of the 24th write, err=0.
REQ-037 SHALL pass this scenario: box (5,5)-(5,5) -> exactly 3 writes at addr 28215/28216/28217 with data 0x00/0x00/0xFF, then done=1.
REQ-038 SHALL pass this scenario: xMin=50, xMax=40 -> zero writes, done=1 and err=1 one cycle after start; a following valid start clears err.
REQ-039 SHALL pass this scenario: waitrequest held high 4 cycles on the first write of box (0,0)-(99,0) -> addr/wrdata stable through the stall, 300 writes total, last addr 29999.
REQ-040 SHALL pass this scenario: rst pulsed mid-LEFT on box (0,0)-(99,99) -> wren=0 with no clk edge, done=0; a restart produces 1188 writes.
REQ-041 SHALL pass this scenario: start held high through a draw of box (0,0)-(1,1) -> 12 writes, then a second draw begins from FIN with done dropping on that edge.
